// File: rtl/blit_patram_pkg.sv
// Shared constants, types and helpers for the blitter pattern RAM.
package blit_pkg;

    localparam int PATRAM_WORDS_DEFAULT = 4096;
    localparam int PATRAM_RD_LATENCY    = 2;
    localparam int BYTE_ADDR_W          = 16;
    localparam int WORD_IDX_W           = BYTE_ADDR_W - 2;

    // Which requester owns the read currently in the RAM stage.
    typedef enum logic {
        SRC_BLIT = 1'b0,
        SRC_CPU  = 1'b1
    } rd_src_e;

    // Byte address to 32-bit word index; the two lane-select bits are dropped.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [BYTE_ADDR_W-1:0] byte_addr);
        return WORD_IDX_W'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/blit_patram_if.sv
// Blitter read port, CPU access port and range-error status of the pattern RAM.
interface blit_patram_if;
    import blit_pkg::*;

    logic                   blitr_patram_req;
    logic [BYTE_ADDR_W-1:0] blitr_patram_addr;
    logic [31:0]            blitr_patram_rdata;
    logic                   blitr_patram_rdvalid;

    logic                   cpu_req;
    logic                   cpu_write;
    logic [BYTE_ADDR_W-1:0] cpu_addr;
    logic [31:0]            cpu_wdata;
    logic [3:0]             cpu_byte_enable;
    logic                   cpu_ack;
    logic [31:0]            cpu_rdata;
    logic                   cpu_rdvalid;

    logic                   range_error;
    logic                   range_error_clear;

    modport master (
        output blitr_patram_req, blitr_patram_addr,
        input  blitr_patram_rdata, blitr_patram_rdvalid,
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_byte_enable,
        input  cpu_ack, cpu_rdata, cpu_rdvalid,
        input  range_error,
        output range_error_clear
    );

    modport slave (
        input  blitr_patram_req, blitr_patram_addr,
        output blitr_patram_rdata, blitr_patram_rdvalid,
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_byte_enable,
        output cpu_ack, cpu_rdata, cpu_rdvalid,
        output range_error,
        input  range_error_clear
    );

endinterface

// File: rtl/blit_patram_mem.sv
// patram_mem: single-port synchronous RAM, 32-bit words, byte-lane writes.
// Contents are deliberately not reset so patterns survive a block reset.
module patram_mem #(
    parameter int WORDS = 4096
) (
    input  logic                     clock,
    input  logic                     en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // One access per cycle: a write updates enabled lanes, a read registers the word.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/blit_patram.sv
// blit_patram: pattern RAM shared by the blitter (never stalled) and the CPU.
// Read path is RAM register plus output register, two cycles end to end.
// Optional macro PATRAM_RANGE_CHECK_EN: out-of-range indices read 0, drop
// writes and raise sticky range_error; otherwise indices wrap.
module blit_patram
    import blit_pkg::*;
#(
    parameter int PATRAM_WORDS = PATRAM_WORDS_DEFAULT
) (
    input logic          clock,
    input logic          reset,
    blit_patram_if.slave bus
);
    localparam int AW = $clog2(PATRAM_WORDS);

    logic [WORD_IDX_W-1:0] blit_idx, cpu_idx, acc_idx;
    logic                  blit_rd, cpu_grant, acc_oor, mem_en, mem_we;
    logic [31:0]           mem_rdata, rd_word;
    logic                  unused_idx;

    logic        s1_valid_q, s1_valid_d;
    rd_src_e     s1_src_q, s1_src_d;
    logic        s1_oor_q, s1_oor_d;
    logic        blit_rdvalid_q, blit_rdvalid_d;
    logic [31:0] blit_rdata_q, blit_rdata_d;
    logic        cpu_rdvalid_q, cpu_rdvalid_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        range_error_q, range_error_d;

    // Decode and arbitrate: the blitter owns every cycle it requests.
    always_comb begin
        blit_idx  = word_index(bus.blitr_patram_addr);
        cpu_idx   = word_index(bus.cpu_addr);
        blit_rd   = bus.blitr_patram_req & ~reset;
        cpu_grant = bus.cpu_req & ~bus.blitr_patram_req & ~reset;
        acc_idx   = blit_rd ? blit_idx : cpu_idx;
`ifdef PATRAM_RANGE_CHECK_EN
        acc_oor   = 32'(acc_idx) >= 32'(PATRAM_WORDS);
`else
        acc_oor   = 1'b0;
`endif
        mem_en    = blit_rd | cpu_grant;
        mem_we    = cpu_grant & bus.cpu_write & ~acc_oor;
    end

    // Upper index bits are ignored when the index wraps.
    assign unused_idx = ^acc_idx;

    patram_mem #(.WORDS(PATRAM_WORDS)) u_mem (
        .clock (clock),
        .en    (mem_en),
        .we    (mem_we),
        .be    (bus.cpu_byte_enable),
        .addr  (acc_idx[AW-1:0]),
        .wdata (bus.cpu_wdata),
        .rdata (mem_rdata)
    );

    // Track the read in flight and steer RAM data to its owner; outputs hold when idle.
    always_comb begin
        s1_valid_d     = blit_rd | (cpu_grant & ~bus.cpu_write);
        s1_src_d       = blit_rd ? SRC_BLIT : SRC_CPU;
        s1_oor_d       = acc_oor;
        rd_word        = s1_oor_q ? 32'h0 : mem_rdata;
        blit_rdvalid_d = s1_valid_q & (s1_src_q == SRC_BLIT);
        cpu_rdvalid_d  = s1_valid_q & (s1_src_q == SRC_CPU);
        blit_rdata_d   = blit_rdvalid_d ? rd_word : blit_rdata_q;
        cpu_rdata_d    = cpu_rdvalid_d ? rd_word : cpu_rdata_q;
        if (bus.range_error_clear) begin
            range_error_d = 1'b0;
        end else begin
            range_error_d = range_error_q | (mem_en & acc_oor);
        end
    end

    // Pipeline and status registers; reset discards any read in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_src_q       <= SRC_BLIT;
            s1_oor_q       <= 1'b0;
            blit_rdvalid_q <= 1'b0;
            blit_rdata_q   <= 32'h0;
            cpu_rdvalid_q  <= 1'b0;
            cpu_rdata_q    <= 32'h0;
            range_error_q  <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_src_q       <= s1_src_d;
            s1_oor_q       <= s1_oor_d;
            blit_rdvalid_q <= blit_rdvalid_d;
            blit_rdata_q   <= blit_rdata_d;
            cpu_rdvalid_q  <= cpu_rdvalid_d;
            cpu_rdata_q    <= cpu_rdata_d;
            range_error_q  <= range_error_d;
        end
    end

    assign bus.cpu_ack              = cpu_grant;
    assign bus.blitr_patram_rdvalid = blit_rdvalid_q;
    assign bus.blitr_patram_rdata   = blit_rdata_q;
    assign bus.cpu_rdvalid          = cpu_rdvalid_q;
    assign bus.cpu_rdata            = cpu_rdata_q;
    assign bus.range_error          = range_error_q;

endmodule

// File: tb/tb_blit_patram.sv
// Testbench for blit_patram: directed scenarios plus randomized traffic,
// every cycle compared against a word-array reference model.
module tb_blit_patram;
    import blit_pkg::*;

    localparam int WORDS = PATRAM_WORDS_DEFAULT;
    localparam int LAT   = PATRAM_RD_LATENCY;

    logic clock = 1'b0;
    logic reset;
    blit_patram_if bus ();

    blit_patram #(.PATRAM_WORDS(WORDS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mmem [WORDS];
    logic        bv_due [8];
    logic        cv_due [8];
    logic [31:0] bd_due [8];
    logic [31:0] cd_due [8];
    logic [31:0] b_last = 32'h0;
    logic [31:0] c_last = 32'h0;
    logic        re_exp = 1'b0;
    logic        rst_prev = 1'b0;
    logic        armed = 1'b0;
    int          cyc = 0;
    int          rv_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic oor(input logic [15:0] a);
`ifdef PATRAM_RANGE_CHECK_EN
        return (int'(a) / 4) >= WORDS;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 4) % WORDS;
    endfunction

    function automatic logic [31:0] mread(input logic [15:0] a);
        if (oor(a)) return 32'h0;
        return mmem[widx(a)];
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[15:14] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic b_req, input logic [15:0] b_addr,
                        input logic c_req, input logic c_wr, input logic [15:0] c_addr,
                        input logic [31:0] c_wd, input logic [3:0] c_be,
                        input logic rst, input logic clr, output logic granted);
        logic g;
        int   s;
        @(negedge clock);
        reset                 = rst;
        bus.blitr_patram_req  = b_req;
        bus.blitr_patram_addr = b_addr;
        bus.cpu_req           = c_req;
        bus.cpu_write         = c_wr;
        bus.cpu_addr          = c_addr;
        bus.cpu_wdata         = c_wd;
        bus.cpu_byte_enable   = c_be;
        bus.range_error_clear = clr;
        #1;
        s = cyc % 8;
        if (rst_prev) begin
            b_last = 32'h0;
            c_last = 32'h0;
        end
        if (bv_due[s]) b_last = bd_due[s];
        if (cv_due[s]) c_last = cd_due[s];
        g = c_req & ~b_req & ~rst;
        if (bus.blitr_patram_rdvalid === 1'b1) rv_seen++;
        if (armed) begin
            chk("blit_rdvalid", 32'(bus.blitr_patram_rdvalid), 32'(bv_due[s]));
            chk("blit_rdata",   bus.blitr_patram_rdata, b_last);
            chk("cpu_rdvalid",  32'(bus.cpu_rdvalid), 32'(cv_due[s]));
            chk("cpu_rdata",    bus.cpu_rdata, c_last);
            chk("cpu_ack",      32'(bus.cpu_ack), 32'(g));
            chk("range_error",  32'(bus.range_error), 32'(re_exp));
        end
        bv_due[s] = 1'b0;
        cv_due[s] = 1'b0;
        if (rst) begin
            bv_due[(cyc + 1) % 8] = 1'b0;
            cv_due[(cyc + 1) % 8] = 1'b0;
            re_exp = 1'b0;
        end else begin
            if (b_req) begin
                bv_due[(cyc + LAT) % 8] = 1'b1;
                bd_due[(cyc + LAT) % 8] = mread(b_addr);
            end else if (g) begin
                if (c_wr) begin
                    if (!oor(c_addr)) begin
                        for (int b = 0; b < 4; b++)
                            if (c_be[b]) mmem[widx(c_addr)][8*b +: 8] = c_wd[8*b +: 8];
                    end
                end else begin
                    cv_due[(cyc + LAT) % 8] = 1'b1;
                    cd_due[(cyc + LAT) % 8] = mread(c_addr);
                end
            end
            if (clr) re_exp = 1'b0;
            else if ((b_req && oor(b_addr)) || (g && oor(c_addr))) re_exp = 1'b1;
        end
        rst_prev = rst;
        if (rst) armed = 1'b1;
        cyc++;
        granted = g;
    endtask

    task automatic idle(input logic rst = 1'b0, input logic clr = 1'b0);
        logic g;
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, rst, clr, g);
    endtask

    task automatic blit_read(input logic [15:0] a, input logic rst = 1'b0, input logic clr = 1'b0);
        logic g;
        step(1'b1, a, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, rst, clr, g);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        logic g;
        step(1'b0, 16'h0, 1'b1, 1'b1, a, d, be, 1'b0, 1'b0, g);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        logic g;
        step(1'b0, 16'h0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0, g);
    endtask

    initial begin
        logic        g;
        logic        cp_req;
        logic        cp_wr;
        logic [15:0] cp_addr;
        logic [31:0] cp_wd;
        logic [3:0]  cp_be;
        int          rv_base;

        for (int i = 0; i < 8; i++) begin
            bv_due[i] = 1'b0;
            cv_due[i] = 1'b0;
            bd_due[i] = 32'h0;
            cd_due[i] = 32'h0;
        end

        repeat (3) idle(1'b1);
        idle();

        for (int i = 0; i < 64; i++) cpu_write(16'(i * 4), $urandom, 4'hF);

        // CPU write then blitter read of the same word on the next cycle.
        cpu_write(16'h0010, 32'hDEADBEEF, 4'hF);
        blit_read(16'h0010);
        idle();
        idle();
        chk("wr_then_blit_valid", 32'(bus.blitr_patram_rdvalid), 32'h1);
        chk("wr_then_blit_data",  bus.blitr_patram_rdata, 32'hDEADBEEF);

        // Single-lane write merges into the existing word.
        cpu_write(16'h0020, 32'h11223344, 4'hF);
        cpu_write(16'h0020, 32'h000000AA, 4'b0001);
        cpu_read(16'h0020);
        idle();
        idle();
        chk("lane0_merge_valid", 32'(bus.cpu_rdvalid), 32'h1);
        chk("lane0_merge_data",  bus.cpu_rdata, 32'h112233AA);

        // Zero byte enables: acked, memory untouched.
        cpu_write(16'h0024, 32'hCAFEF00D, 4'h0);
        cpu_read(16'h0024);
        idle();
        idle();

        // Five-cycle blitter burst starves a held CPU read; ack follows the burst.
        rv_base = rv_seen;
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'(i * 4), 1'b1, 1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 1'b0, g);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 1'b0, g);
        chk("burst_ack_after", 32'(g), 32'h1);
        idle();
        idle();
        chk("burst_pulses", 32'(rv_seen - rv_base), 32'd5);

        // Reset drops reads already in flight.
        blit_read(16'h0000);
        rv_base = rv_seen;
        blit_read(16'h0004, 1'b1);
        idle();
        idle();
        chk("reset_drop_pulses", 32'(rv_seen - rv_base), 32'd0);

        // Read past the end of the RAM.
        blit_read(16'h4000);
        idle();
        idle();
`ifdef PATRAM_RANGE_CHECK_EN
        chk("oor_rdata", bus.blitr_patram_rdata, 32'h0);
        chk("oor_flag",  32'(bus.range_error), 32'h1);
        idle(1'b0, 1'b1);
        idle();
        chk("oor_cleared", 32'(bus.range_error), 32'h0);
`else
        chk("wrap_rdata", bus.blitr_patram_rdata, mmem[0]);
        chk("wrap_flag",  32'(bus.range_error), 32'h0);
`endif
        // Clear in the same cycle as a new error wins.
        blit_read(16'h4004, 1'b0, 1'b1);
        idle();
        chk("clear_priority", 32'(bus.range_error), 32'h0);

        // Randomized mixed traffic with occasional reset and clear.
        cp_req = 1'b0;
        cp_wr = 1'b0;
        cp_addr = 16'h0;
        cp_wd = 32'h0;
        cp_be = 4'h0;
        for (int i = 0; i < 800; i++) begin
            logic        br, rs, cl;
            logic [15:0] ba;
            if (!cp_req && $urandom_range(0, 2) == 0) begin
                cp_req  = 1'b1;
                cp_wr   = 1'($urandom_range(0, 1));
                cp_addr = rand_addr();
                cp_wd   = $urandom;
                cp_be   = 4'($urandom);
            end
            br = 1'($urandom_range(0, 1));
            ba = rand_addr();
            rs = ($urandom_range(0, 63) == 0);
            cl = ($urandom_range(0, 15) == 0);
            step(br, ba, cp_req, cp_wr, cp_addr, cp_wd, cp_be, rs, cl, g);
            if (g) cp_req = 1'b0;
        end
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/blit_patram.md
BLIT_PATRAM -- requirements
Module: blit_patram

Interface
REQ-001 Parameter: PATRAM_WORDS, default 4096; depth of pattern RAM in 32-bit words, power of two.
REQ-002 Port: clock  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: blitr_patram_req  input  1  blitter read request; one read per high cycle; no backpressure.
REQ-005 Port: blitr_patram_addr  input  16  blitter byte address; bits [1:0] ignored.
REQ-006 Port: blitr_patram_rdata  output  32  blitter read data.
REQ-007 Port: blitr_patram_rdvalid  output  1  rdata valid, one pulse per accepted request.
REQ-008 Port: cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-009 Port: cpu_write  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-010 Port: cpu_addr  input  16  CPU byte address; bits [1:0] ignored.
REQ-011 Port: cpu_wdata  input  32  CPU write data.
REQ-012 Port: cpu_byte_enable  input  4  CPU write byte lanes; bit n enables bits [8n+7:8n].
REQ-013 Port: cpu_ack  output  1  single-cycle grant of the current CPU request.
REQ-014 Port: cpu_rdata  output  32  CPU read data.
REQ-015 Port: cpu_rdvalid  output  1  cpu_rdata valid, one pulse per granted read.
REQ-016 Port: range_error  output  1  sticky out-of-range flag.
REQ-017 Port: range_error_clear  input  1  clears range_error.

Function
REQ-018 The block SHALL contain one single-port RAM of PATRAM_WORDS x 32 bits, with one access per cycle.
REQ-019 Arbitration: blitr_patram_req SHALL always win, because the blitter cannot be stalled; the CPU is granted only in cycles with blitr_patram_req low.
REQ-020 cpu_ack SHALL be asserted in the grant cycle only, and never in a cycle where blitr_patram_req is high.
REQ-021 Blitter read latency SHALL be exactly 2 cycles: request at cycle N gives rdvalid and rdata at N+2 (RAM register plus output register).
REQ-022 Back-to-back blitter requests SHALL give back-to-back rdvalid pulses, in order, with no gaps.
REQ-023 A CPU read granted at N SHALL give cpu_rdvalid and cpu_rdata at N+2.
REQ-024 A CPU write granted at N SHALL update only the enabled byte lanes at the clock edge ending N; any read issued at N+1 or later returns the new data.
REQ-025 cpu_byte_enable = 0 on a write SHALL still assert cpu_ack and leave memory unchanged.
REQ-026 Word index SHALL be addr[15:2]; address-range handling follows REQ-032 and REQ-033.
REQ-027 blitr_patram_rdata and cpu_rdata SHALL hold their last value when not valid.
REQ-028 range_error_clear SHALL take priority over a new error detected in the same cycle.

Reset
REQ-029 On reset, blitr_patram_rdvalid, cpu_rdvalid, cpu_ack and range_error SHALL be 0; the rdata outputs SHALL be 0.
REQ-030 Reset mid-operation SHALL drop all in-flight reads: no rdvalid is produced for requests issued before or during reset.
REQ-031 RAM contents SHALL NOT be reset; they SHALL survive reset.

Configuration
REQ-032 With PATRAM_RANGE_CHECK_EN defined: a word index >= PATRAM_WORDS SHALL return 0 for reads, suppress writes (which are still acked), and set range_error on the next cycle.
REQ-033 Without PATRAM_RANGE_CHECK_EN: the index SHALL wrap modulo PATRAM_WORDS, and range_error SHALL be tied to 0.

Structure
REQ-034 blit_pkg SHALL hold the PATRAM_WORDS default, a PATRAM_RD_LATENCY = 2 constant, and the byte-address-to-word-index width constant.
REQ-035 The RAM SHALL be a separate sub-module, patram_mem: an inferred single-port synchronous RAM with byte enables and no reset.
REQ-036 The top level SHALL hold the arbitration, the valid/source pipeline and the range check.

Verification
REQ-037 CPU write 0xDEADBEEF, BE=4'hF, addr 0x0010; blitter read 0x0010 one cycle later -> rdvalid two cycles after the request, rdata = 0xDEADBEEF.
REQ-038 CPU write 0x000000AA, BE=4'b0001 over a word holding 0x11223344 -> CPU read returns 0x112233AA.
REQ-039 blitr_patram_req high for 5 cycles while cpu_req is held -> five consecutive rdvalid pulses; cpu_ack first asserts in the cycle after req drops.
REQ-040 Blitter reads issued at cycles N and N+1, reset asserted at N+1 -> no rdvalid at N+2 or N+3.
REQ-041 With PATRAM_RANGE_CHECK_EN and PATRAM_WORDS=4096: read at addr 0x4000 -> rdata 0 and range_error = 1; pulse range_error_clear -> range_error 0. Without the macro, the same read returns the word at 0x0000.
